// File: rtl/exe_stage.sv
// Execute stage of the five-stage CPU: pipeline register between decode and
// memory, integer ALU, data-SRAM request generation, overflow/misalign
// exceptions, and forwarding / load-use hazard export.
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  // decode -> execute handshake and payload
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [11:0] ds_alu_op,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic        ds_ov_chk,
  input  logic        ds_mem_we,
  input  logic        ds_res_from_mem,
  input  logic [1:0]  ds_mem_size,
  input  logic [31:0] ds_store_data,
  input  logic        ds_gr_we,
  input  logic [4:0]  ds_dest,
  input  logic [31:0] ds_pc,
  // execute -> memory handshake and payload
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic        es_res_from_mem,
  output logic [1:0]  es_mem_size,
  output logic [31:0] es_pc,
  output logic        es_ex_ov,
  output logic        es_ex_ale,
  // data SRAM request
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  // hazard / forwarding export
  output logic        es_fwd_valid,
  output logic [4:0]  es_fwd_dest,
  output logic [31:0] es_fwd_data,
  output logic        es_load_hazard
);

  // One-hot ALU; multiple set bits OR their results together, none gives 0.
  function automatic logic [31:0] alu_calc(input logic [11:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sra_v;
    sa    = a;
    sb    = b;
    sra_v = sb >>> a[4:0];
    r     = '0;
    if (op[0])  r |= a + b;
    if (op[1])  r |= a - b;
    if (op[2])  r |= {31'b0, (sa < sb)};
    if (op[3])  r |= {31'b0, (a < b)};
    if (op[4])  r |= a & b;
    if (op[5])  r |= ~(a | b);
    if (op[6])  r |= a | b;
    if (op[7])  r |= a ^ b;
    if (op[8])  r |= b << a[4:0];
    if (op[9])  r |= b >> a[4:0];
    if (op[10]) r |= sra_v;
    if (op[11]) r |= {b[15:0], 16'b0};
    return r;
  endfunction

  // Signed overflow of s = a + b, where b is already the effective operand.
  function automatic logic add_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input logic signed [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Size 3 is reserved and handled as a word access.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = addr_lo[0];
      default: m = (addr_lo != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << addr_lo;
      2'd1:    s = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated across byte lanes so the strobe picks the lane.
  function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                              input logic [31:0] data);
    logic [31:0] w;
    case (size)
      2'd0:    w = {4{data[7:0]}};
      2'd1:    w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  logic        vld_p1;
  logic [11:0] alu_op_p1;
  logic [31:0] src1_p1;
  logic [31:0] src2_p1;
  logic        ov_chk_p1;
  logic        mem_we_p1;
  logic        load_p1;
  logic [1:0]  size_p1;
  logic [31:0] sdata_p1;
  logic        gr_we_p1;
  logic [4:0]  dest_p1;
  logic [31:0] pc_p1;

  logic        accept_p0;
  logic signed [31:0] sum_p1;
  logic signed [31:0] diff_p1;
  logic        ov_p1;
  logic        ale_p1;
  logic        ex_p1;
  logic        mem_acc_p1;

  // ---- decode -> execute boundary ----
  // Stage never needs more than one cycle, so it frees up whenever memory takes.
  assign es_allowin = !vld_p1 || ms_allowin;
  assign accept_p0  = ds_to_es_valid && es_allowin && !flush;

  // Stage valid: a flush kills both the resident and any arriving instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (es_allowin) begin
      vld_p1 <= ds_to_es_valid;
    end
  end

  // Payload register: captured only on an accepted, unflushed handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_p1 <= '0;
      src1_p1   <= '0;
      src2_p1   <= '0;
      ov_chk_p1 <= 1'b0;
      mem_we_p1 <= 1'b0;
      load_p1   <= 1'b0;
      size_p1   <= '0;
      sdata_p1  <= '0;
      gr_we_p1  <= 1'b0;
      dest_p1   <= '0;
      pc_p1     <= '0;
    end else if (accept_p0) begin
      alu_op_p1 <= ds_alu_op;
      src1_p1   <= ds_alu_src1;
      src2_p1   <= ds_alu_src2;
      ov_chk_p1 <= ds_ov_chk;
      mem_we_p1 <= ds_mem_we;
      load_p1   <= ds_res_from_mem;
      size_p1   <= ds_mem_size;
      sdata_p1  <= ds_store_data;
      gr_we_p1  <= ds_gr_we;
      dest_p1   <= ds_dest;
      pc_p1     <= ds_pc;
    end
  end

  // ---- execute -> memory boundary ----
  assign es_result = alu_calc(alu_op_p1, src1_p1, src2_p1);

  // Subtraction overflow is judged on the inverted second operand.
  assign sum_p1  = src1_p1 + src2_p1;
  assign diff_p1 = src1_p1 - src2_p1;
  assign ov_p1   = ov_chk_p1 &&
                   ((alu_op_p1[0] && add_ovf(src1_p1, src2_p1, sum_p1)) ||
                    (alu_op_p1[1] && add_ovf(src1_p1, ~src2_p1, diff_p1)));

  assign mem_acc_p1 = mem_we_p1 || load_p1;
  assign ale_p1     = mem_acc_p1 && misaligned(size_p1, es_result[1:0]);

  assign es_ex_ov  = vld_p1 && ov_p1;
  assign es_ex_ale = vld_p1 && ale_p1;
  assign ex_p1     = es_ex_ov || es_ex_ale;

  assign es_to_ms_valid  = vld_p1 && !flush;
  assign es_dest         = dest_p1;
  assign es_gr_we        = gr_we_p1 && !ex_p1;
  assign es_res_from_mem = load_p1;
  assign es_mem_size     = size_p1;
  assign es_pc           = pc_p1;

  // The request is tied to the handoff cycle, so a stalled access cannot
  // issue twice: it only fires when memory accepts the instruction.
  assign data_sram_en    = vld_p1 && mem_acc_p1 && ms_allowin && !flush && !ex_p1;
  assign data_sram_we    = (data_sram_en && mem_we_p1) ?
                           store_strobe(size_p1, es_result[1:0]) : 4'b0000;
  assign data_sram_addr  = es_result;
  assign data_sram_wdata = store_wdata(size_p1, sdata_p1);

  // Writes to r0 are never worth forwarding.
  assign es_fwd_valid   = vld_p1 && es_gr_we && (dest_p1 != 5'd0);
  assign es_fwd_dest    = dest_p1;
  assign es_fwd_data    = es_result;
  assign es_load_hazard = vld_p1 && load_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors push hand-computed
// expectations; a negedge monitor pops one per handoff to memory.
module tb_exe_stage;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  logic        clk = 1'b0;
  logic        reset, flush, ds_to_es_valid, es_allowin;
  logic [11:0] ds_alu_op;
  logic [31:0] ds_alu_src1, ds_alu_src2, ds_store_data, ds_pc;
  logic        ds_ov_chk, ds_mem_we, ds_res_from_mem, ds_gr_we;
  logic [1:0]  ds_mem_size;
  logic [4:0]  ds_dest;
  logic        ms_allowin, es_to_ms_valid;
  logic [31:0] es_result, es_pc;
  logic [4:0]  es_dest;
  logic        es_gr_we, es_res_from_mem, es_ex_ov, es_ex_ale;
  logic [1:0]  es_mem_size;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        es_fwd_valid, es_load_hazard;
  logic [4:0]  es_fwd_dest;
  logic [31:0] es_fwd_data;

  exe_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_alu_op(ds_alu_op), .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2),
    .ds_ov_chk(ds_ov_chk), .ds_mem_we(ds_mem_we), .ds_res_from_mem(ds_res_from_mem),
    .ds_mem_size(ds_mem_size), .ds_store_data(ds_store_data), .ds_gr_we(ds_gr_we),
    .ds_dest(ds_dest), .ds_pc(ds_pc), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_result(es_result), .es_dest(es_dest),
    .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem), .es_mem_size(es_mem_size),
    .es_pc(es_pc), .es_ex_ov(es_ex_ov), .es_ex_ale(es_ex_ale),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data),
    .es_load_hazard(es_load_hazard)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        ale;
    logic        gw;
    logic        en;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [4:0]  dest;
    logic        ld;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] pc_ctr  = 32'h1c00_0000;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
  endtask

  task automatic drive(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic ovc, input logic mw, input logic ld,
                       input logic [1:0] sz, input logic [31:0] sd,
                       input logic gw, input logic [4:0] dst);
    ds_alu_op = op; ds_alu_src1 = s1; ds_alu_src2 = s2; ds_ov_chk = ovc;
    ds_mem_we = mw; ds_res_from_mem = ld; ds_mem_size = sz; ds_store_data = sd;
    ds_gr_we = gw; ds_dest = dst; ds_pc = pc_ctr;
  endtask

  // Presents one instruction for one cycle; called at posedge+1 with the stage able to accept.
  task automatic issue(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic ovc, input logic mw, input logic ld,
                       input logic [1:0] sz, input logic [31:0] sd,
                       input logic gw, input logic [4:0] dst,
                       input logic [31:0] e_res, input logic e_ov, input logic e_ale,
                       input logic e_gw, input logic e_en, input logic [3:0] e_we,
                       input logic [31:0] e_wd, input bit push);
    exp_t e;
    drive(op, s1, s2, ovc, mw, ld, sz, sd, gw, dst);
    e = '{res: e_res, ov: e_ov, ale: e_ale, gw: e_gw, en: e_en, we: e_we,
          wd: e_wd, dest: dst, ld: ld, pc: pc_ctr};
    if (push) q.push_back(e);
    pc_ctr = pc_ctr + 32'd4;
    ds_to_es_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ds_to_es_valid = 1'b0;
  endtask

  // Monitor: one expectation per instruction handed to the memory stage.
  always @(negedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      if (q.size() == 0) begin
        check(1'b0, "unexpected_handoff", es_pc, 32'h0);
      end else begin
        cur = q.pop_front();
        check(es_result == cur.res, "result", es_result, cur.res);
        check(es_ex_ov == cur.ov, "ex_ov", 32'(es_ex_ov), 32'(cur.ov));
        check(es_ex_ale == cur.ale, "ex_ale", 32'(es_ex_ale), 32'(cur.ale));
        check(es_gr_we == cur.gw, "gr_we", 32'(es_gr_we), 32'(cur.gw));
        check(data_sram_en == cur.en, "sram_en", 32'(data_sram_en), 32'(cur.en));
        check(data_sram_we == cur.we, "sram_we", 32'(data_sram_we), 32'(cur.we));
        if (cur.en && cur.we != 4'b0000)
          check(data_sram_wdata == cur.wd, "sram_wdata", data_sram_wdata, cur.wd);
        if (cur.en)
          check(data_sram_addr == cur.res, "sram_addr", data_sram_addr, cur.res);
        check(es_dest == cur.dest, "dest", 32'(es_dest), 32'(cur.dest));
        check(es_pc == cur.pc, "pc", es_pc, cur.pc);
        check(es_fwd_valid == (cur.gw && cur.dest != 5'd0), "fwd_valid",
              32'(es_fwd_valid), 32'(cur.gw && cur.dest != 5'd0));
        check(es_load_hazard == cur.ld, "load_hazard", 32'(es_load_hazard), 32'(cur.ld));
      end
    end
    if (data_sram_en)
      check(es_to_ms_valid && ms_allowin, "en_only_at_handoff", 32'(es_to_ms_valid), 32'h1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0x%08h, expected 0x%08h", n_total, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; ds_to_es_valid = 1'b0; ms_allowin = 1'b1;
    drive(12'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check(es_to_ms_valid == 1'b0, "rst_to_ms_valid", 32'(es_to_ms_valid), 32'h0);
    check(es_allowin == 1'b1, "rst_allowin", 32'(es_allowin), 32'h1);
    check(data_sram_en == 1'b0, "rst_sram_en", 32'(data_sram_en), 32'h0);
    check(es_result == 32'h0, "rst_result", es_result, 32'h0);
    check(es_fwd_valid == 1'b0, "rst_fwd_valid", 32'(es_fwd_valid), 32'h0);
    @(posedge clk); #1;

    // back-to-back stream, one instruction per cycle
    issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 1,0,0, 2'd2, 32'h0, 1, 5'd5,
          32'h80000000, 1,0,0,0, 4'h0, 32'h0, 1);
    issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 0,0,0, 2'd2, 32'h0, 1, 5'd5,
          32'h80000000, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_ADD, 32'h1000, 32'h3, 0,1,0, 2'd0, 32'h12345678, 0, 5'd0,
          32'h1003, 0,0,0,1, 4'b1000, 32'h78787878, 1);
    issue(OP_SRA, 32'h4, 32'h80000000, 0,0,0, 2'd0, 32'h0, 1, 5'd6,
          32'hF8000000, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_SLTU, 32'h1, 32'hFFFFFFFF, 0,0,0, 2'd0, 32'h0, 1, 5'd7,
          32'h1, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_SUB, 32'h5, 32'h7, 1,0,0, 2'd0, 32'h0, 1, 5'd8,
          32'hFFFFFFFE, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_SUB, 32'h80000000, 32'h1, 1,0,0, 2'd0, 32'h0, 1, 5'd9,
          32'h7FFFFFFF, 1,0,0,0, 4'h0, 32'h0, 1);
    issue(OP_SLT, 32'hFFFFFFFF, 32'h1, 0,0,0, 2'd0, 32'h0, 1, 5'd10,
          32'h1, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_NOR, 32'h0, 32'h0F0F0F0F, 0,0,0, 2'd0, 32'h0, 1, 5'd11,
          32'hF0F0F0F0, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_LUI, 32'h0, 32'h00001234, 0,0,0, 2'd0, 32'h0, 1, 5'd12,
          32'h12340000, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_ADD, 32'h2000, 32'h2, 0,1,0, 2'd1, 32'hAABBCCDD, 0, 5'd0,
          32'h2002, 0,0,0,1, 4'b1100, 32'hCCDDCCDD, 1);
    issue(OP_ADD, 32'h1000, 32'h2, 0,0,1, 2'd2, 32'h0, 1, 5'd13,
          32'h1002, 0,1,0,0, 4'h0, 32'h0, 1);
    issue(OP_OR | OP_AND, 32'hF0, 32'h3C, 0,0,0, 2'd0, 32'h0, 1, 5'd14,
          32'hFC, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(12'h000, 32'h1234, 32'h5678, 0,0,0, 2'd0, 32'h0, 1, 5'd0,
          32'h0, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_ADD, 32'h2000, 32'h1, 0,1,0, 2'd1, 32'h0, 0, 5'd0,
          32'h2001, 0,1,0,0, 4'h0, 32'h0, 1);
    issue(OP_SLL, 32'h24, 32'h1, 0,0,0, 2'd0, 32'h0, 1, 5'd15,
          32'h10, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_SRL, 32'h8, 32'h80000000, 0,0,0, 2'd0, 32'h0, 1, 5'd16,
          32'h00800000, 0,0,1,0, 4'h0, 32'h0, 1);
    issue(OP_ADD, 32'h3000, 32'h8, 0,1,0, 2'd3, 32'h11223344, 0, 5'd0,
          32'h3008, 0,0,0,1, 4'b1111, 32'h11223344, 1);
    idle();
    repeat (2) @(posedge clk); #1;

    // word store held by a 3-cycle memory stall
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'h3000, 32'h4, 0,1,0, 2'd2, 32'hDEADBEEF, 0, 5'd0,
          32'h3004, 0,0,0,1, 4'b1111, 32'hDEADBEEF, 1);
    idle();
    repeat (3) begin
      @(negedge clk);
      check(data_sram_en == 1'b0, "stall_sram_en", 32'(data_sram_en), 32'h0);
      check(es_allowin == 1'b0, "stall_allowin", 32'(es_allowin), 32'h0);
      check(es_to_ms_valid == 1'b1, "stall_to_ms_valid", 32'(es_to_ms_valid), 32'h1);
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    check(data_sram_en == 1'b1, "release_sram_en", 32'(data_sram_en), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check(data_sram_en == 1'b0, "no_reissue", 32'(data_sram_en), 32'h0);
    check(es_to_ms_valid == 1'b0, "after_release_valid", 32'(es_to_ms_valid), 32'h0);
    @(posedge clk); #1;

    // flush a stalled store while decode offers a new instruction
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'h40, 32'h0, 0,1,0, 2'd2, 32'h55, 0, 5'd0,
          32'h40, 0,0,0,0, 4'h0, 32'h0, 0);
    ms_allowin = 1'b1;
    flush = 1'b1;
    drive(OP_ADD, 32'h100, 32'h1, 0,0,0, 2'd2, 32'h0, 1, 5'd3);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    check(es_to_ms_valid == 1'b0, "flush_to_ms_valid", 32'(es_to_ms_valid), 32'h0);
    check(data_sram_en == 1'b0, "flush_sram_en", 32'(data_sram_en), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    check(es_to_ms_valid == 1'b0, "post_flush_valid", 32'(es_to_ms_valid), 32'h0);
    check(es_result == 32'h40, "flush_not_latched", es_result, 32'h40);
    check(es_load_hazard == 1'b0, "post_flush_hazard", 32'(es_load_hazard), 32'h0);
    @(posedge clk); #1;

    // asynchronous reset while a store is stalled
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'h80, 32'h0, 0,1,0, 2'd2, 32'h99, 0, 5'd0,
          32'h80, 0,0,0,0, 4'h0, 32'h0, 0);
    idle();
    #1 reset = 1'b1;
    #1 ms_allowin = 1'b1;
    #1;
    check(es_to_ms_valid == 1'b0, "async_rst_valid", 32'(es_to_ms_valid), 32'h0);
    check(data_sram_en == 1'b0, "async_rst_sram_en", 32'(data_sram_en), 32'h0);
    check(es_result == 32'h0, "async_rst_result", es_result, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check(es_to_ms_valid == 1'b0, "post_rst_valid", 32'(es_to_ms_valid), 32'h0);
    check(es_result == 32'h0, "post_rst_result", es_result, 32'h0);
    @(posedge clk); #1;
    issue(OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 0,0,0, 2'd0, 32'h0, 1, 5'd17,
          32'hF00FF00F, 0,0,1,0, 4'h0, 32'h0, 1);
    idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check(q.size() == 0, "queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute pipeline stage between decode and memory in the five-stage CPU.
- Latches the decode payload into a valid/allowin pipeline register and drives the integer ALU (alu_op/alu_src1/alu_src2 → alu_result/alu_ov).
- Forms the data-SRAM request for loads and stores, flags overflow and misaligned-access exceptions, and exports forwarding and load-use hazard information.

Parameters:
None.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  exception/ertn flush from writeback; kills the in-stage instruction
ds_to_es_valid  in  1  decode has an instruction for this stage
es_allowin  out  1  stage can accept this cycle
ds_alu_op  in  12  one-hot ALU op: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui
ds_alu_src1  in  32  operand 1 (shift amount in [4:0] for shifts)
ds_alu_src2  in  32  operand 2
ds_ov_chk  in  1  trap on signed overflow (add/sub only)
ds_mem_we  in  1  store
ds_res_from_mem  in  1  load
ds_mem_size  in  2  0 byte, 1 half, 2 word (3 reserved, treated as word)
ds_store_data  in  32  rt/rd value for stores
ds_gr_we  in  1  register write enable
ds_dest  in  5  destination register
ds_pc  in  32  PC
ms_allowin  in  1  memory stage can accept
es_to_ms_valid  out  1  valid to memory stage
es_result  out  32  ALU result (memory address for loads/stores)
es_dest  out  5  latched dest
es_gr_we  out  1  gated write enable (0 on exception)
es_res_from_mem  out  1  latched load flag
es_mem_size  out  2  latched size
es_pc  out  32  latched PC
es_ex_ov  out  1  overflow exception
es_ex_ale  out  1  address-misaligned exception
data_sram_en  out  1  SRAM request
data_sram_we  out  4  byte write strobes
data_sram_addr  out  32  address
data_sram_wdata  out  32  replicated store data
es_fwd_valid  out  1  forwarding entry valid (es_valid & es_gr_we & dest≠0)
es_fwd_dest  out  5  forwarding dest
es_fwd_data  out  32  forwarding data (es_result)
es_load_hazard  out  1  es_valid & es_res_from_mem; decode must stall on a dest match

Behaviour:
- es_ready_go is constant 1.
- es_allowin = !es_valid | ms_allowin.
- es_to_ms_valid = es_valid & !flush.
- es_valid register:
  - reset → 0.
  - else if flush → 0.
  - else if es_allowin → ds_to_es_valid.
- Payload registers (all ds_* fields):
  - Load only when ds_to_es_valid & es_allowin & !flush.
  - Hold otherwise.
  - Reset value 0.
- Stage output latency: 1 cycle from acceptance.
- ALU result function:
  - add/sub: 32-bit two's complement, carry discarded.
  - slt: signed compare; sltu: unsigned compare; result is 0 or 1.
  - nor = ~(a|b).
  - sll/srl/sra: shift src2 by src1[4:0]; sra sign-fills from src2[31].
  - lui: {src2[15:0],16'b0}.
  - More than one op bit set: results ORed. No op bit set: result 0.
- Exceptions:
  - es_ex_ov = es_valid & ov_chk & (add|sub) & signed overflow of the effective operands (src2 inverted for sub).
  - es_ex_ale = es_valid & (load|store) & misalignment: half with addr[0]≠0, word with addr[1:0]≠0.
  - Any exception forces es_gr_we=0 and suppresses data_sram_en.
  - es_fwd_valid is gated the same way.
- SRAM request:
  - data_sram_en = es_valid & (mem_we|res_from_mem) & ms_allowin & !flush & !exception.
  - Issued exactly once, in the handoff cycle; no re-issue while stalled.
  - data_sram_addr = es_result.
  - Byte store: we = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - Half store: we = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - Word store: we = 4'b1111; wdata = data.
  - Loads and idle: we = 0.
- Boundary conditions:
  - flush and ds_to_es_valid in the same cycle → the new instruction is not accepted.
  - Reset asserted mid-stall → es_valid 0 immediately (asynchronous), no SRAM request.
  - Back-to-back with ms_allowin=1 → one instruction per cycle.

Test Plan:
- add, ov_chk=1, src1=0x7FFFFFFF, src2=1 → es_result=0x80000000, es_ex_ov=1, es_gr_we=0; ov_chk=0 → ex_ov=0, gr_we=1.
- Store byte, src1=0x1000, src2=3, data=0x12345678 → addr=0x1003, we=4'b1000, wdata=0x78787878, en=1 for one cycle.
- Word store, ms_allowin low 3 cycles then high → data_sram_en=0 during stall, 1 only in the release cycle; es_allowin=0 during the stall.
- Word load at addr 0x1002 → es_ex_ale=1, data_sram_en=0, es_to_ms_valid=1.
- flush while a stalled valid instruction is in-stage, with ds_to_es_valid=1 → next cycle es_valid=0, no request, new instruction not latched.
- sra src1=4, src2=0x80000000 → 0xF8000000; sltu 1 vs 0xFFFFFFFF → 1; reset pulse mid-stream → es_to_ms_valid=0 and es_result=0 (payload cleared) until the next valid instruction is accepted.
